pipe_ctrl_unit: RTL

//  Next-generation main control for the pipelined MIPS core: decodes the ID-stage opcode/func
//  and registers the control bundle into the ID/EX stage register. Adds load-use hazard detection

---
 rtl/pipe_ctrl_unit.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl_unit.sv
// Main pipeline control for the MIPS core. Decodes the ID-stage instruction and registers the
// control bundle into ID/EX. It also handles load-use stalls, flush, hold, illegal opcodes and bubble counting.
module pipe_ctrl_unit #(
    parameter int LU_STALL = 1,
    parameter int EN_BNE   = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [5:0]       i_opcode,
    input  logic [5:0]       i_func,
    input  logic [4:0]       i_rs,
    input  logic [4:0]       i_rt,
    input  logic [4:0]       i_rd,
    input  logic             i_hold,
    input  logic             i_flush,
    output logic             o_stall,
    output logic             o_ex_valid,
    output logic [1:0]       o_ex_aluop,
    output logic             o_ex_alusrc,
    output logic [1:0]       o_ex_memtoreg,
    output logic             o_ex_memwrite,
    output logic             o_ex_regwrite,
    output logic             o_ex_branch,
    output logic             o_ex_bne,
    output logic             o_ex_jump,
    output logic             o_ex_jr,
    output logic             o_ex_extop,
    output logic [4:0]       o_ex_wreg,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_bubble_cnt
);

    typedef struct packed {
        logic       valid;
        logic [1:0] aluop;
        logic       alusrc;
        logic [1:0] memtoreg;
        logic       memwrite;
        logic       regwrite;
        logic       branch;
        logic       bne;
        logic       jump;
        logic       jr;
        logic       extop;
        logic [4:0] wreg;
    } ctl_t;

    typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

    localparam logic [1:0]       LU_M1   = 2'(LU_STALL - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t     state_r;
    logic [1:0] cnt_r;
    ctl_t       ex_r;
    ctl_t       dec_s;
    logic [4:0] wsel_s;
    logic       illegal_s;
    logic       rt_src_s;
    logic       hazard_s;
    logic       stall_s;

    // Combinational decode of the ID-stage opcode/func into the control bundle
    always_comb begin
        dec_s       = '0;
        dec_s.valid = 1'b1;
        wsel_s      = 5'd0;
        illegal_s   = 1'b0;
        rt_src_s    = 1'b0;
        case (i_opcode)
            6'd0: begin
                dec_s.aluop    = 2'b01;
                dec_s.jr       = (i_func == 6'd8);
                dec_s.regwrite = (i_func != 6'd8);
                dec_s.extop    = (i_func == 6'd0) || (i_func == 6'd2) || (i_func == 6'd3);
                wsel_s         = i_rd;
                rt_src_s       = 1'b1;
            end
            6'd8, 6'd10, 6'd12, 6'd13, 6'd14: begin
                dec_s.alusrc   = 1'b1;
                dec_s.regwrite = 1'b1;
                dec_s.aluop    = 2'b01;
                wsel_s         = i_rt;
            end
            6'd35: begin
                dec_s.alusrc   = 1'b1;
                dec_s.regwrite = 1'b1;
                dec_s.memtoreg = 2'b01;
                wsel_s         = i_rt;
            end
            6'd43: begin
                dec_s.alusrc   = 1'b1;
                dec_s.memwrite = 1'b1;
                rt_src_s       = 1'b1;
            end
            6'd4: begin
                dec_s.branch = 1'b1;
                dec_s.aluop  = 2'b10;
                rt_src_s     = 1'b1;
            end
            6'd5: begin
                rt_src_s = 1'b1;
                if (EN_BNE != 0) begin
                    dec_s.branch = 1'b1;
                    dec_s.bne    = 1'b1;
                    dec_s.aluop  = 2'b10;
                end else begin
                    illegal_s = 1'b1;
                end
            end
            6'd2: begin
                dec_s.jump = 1'b1;
            end
            6'd3: begin
                dec_s.jump     = 1'b1;
                dec_s.regwrite = 1'b1;
                dec_s.memtoreg = 2'b10;
                wsel_s         = 5'd31;
            end
            default: begin
                illegal_s = 1'b1;
            end
        endcase
        // A non-writing instruction targets r0 so it can never look like a hazard source
        dec_s.wreg = dec_s.regwrite ? wsel_s : 5'd0;
    end

    assign hazard_s = ex_r.valid && (ex_r.memtoreg == 2'b01) && (ex_r.wreg != 5'd0) && i_valid &&
                      ((ex_r.wreg == i_rs) || ((ex_r.wreg == i_rt) && rt_src_s));
    assign stall_s  = ((state_r == RUN) && hazard_s) || (state_r == STALL);
    assign o_stall  = stall_s;

    // Stall FSM, ID/EX register, illegal pulse and bubble counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= RUN;
            cnt_r        <= 2'd0;
            ex_r         <= '0;
            o_illegal    <= 1'b0;
            o_bubble_cnt <= '0;
        end else if (i_hold) begin
            o_illegal <= 1'b0;
        end else if (i_flush) begin
            state_r   <= RUN;
            cnt_r     <= 2'd0;
            ex_r      <= '0;
            o_illegal <= 1'b0;
        end else if (stall_s) begin
            ex_r      <= '0;
            o_illegal <= 1'b0;
            if (o_bubble_cnt != CNT_MAX) begin
                o_bubble_cnt <= o_bubble_cnt + CNT_W'(1);
            end else begin
                o_bubble_cnt <= o_bubble_cnt;
            end
            if (state_r == STALL) begin
                if (cnt_r == 2'd1) begin
                    state_r <= RUN;
                    cnt_r   <= 2'd0;
                end else begin
                    cnt_r <= cnt_r - 2'd1;
                end
            end else if (LU_STALL > 1) begin
                state_r <= STALL;
                cnt_r   <= LU_M1;
            end else begin
                state_r <= RUN;
            end
        end else begin
            ex_r      <= i_valid ? dec_s : '0;
            o_illegal <= i_valid && illegal_s;
        end
    end

    assign o_ex_valid    = ex_r.valid;
    assign o_ex_aluop    = ex_r.aluop;
    assign o_ex_alusrc   = ex_r.alusrc;
    assign o_ex_memtoreg = ex_r.memtoreg;
    assign o_ex_memwrite = ex_r.memwrite;
    assign o_ex_regwrite = ex_r.regwrite;
    assign o_ex_branch   = ex_r.branch;
    assign o_ex_bne      = ex_r.bne;
    assign o_ex_jump     = ex_r.jump;
    assign o_ex_jr       = ex_r.jr;
    assign o_ex_extop    = ex_r.extop;
    assign o_ex_wreg     = ex_r.wreg;

endmodule
